// File: rtl/fetch_npc_btb_pkg.sv
// Shared fetch-stage constants: default PC width, BTB geometry and reset PC,
// plus the instruction-alignment shift used to form BTB index/tag slices.
package fetch_npc_btb_pkg;

   localparam int unsigned PC_W_DEF        = 32;
   localparam int unsigned BTB_IDX_W_DEF   = 4;
   localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
   // Instructions are word aligned; PC[1:0] never takes part in index or tag.
   localparam int unsigned INST_ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_npc_btb_btb_ram.sv
// Direct-mapped BTB storage.
// Ports:
//   clk, rst             clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx               lookup index (asynchronous read)
//   rd_valid/tag/target/cond  contents of the entry at rd_idx
//   wr_en, wr_idx        synchronous write strobe and index
//   wr_tag/target/cond   entry payload written with valid=1
module fetch_npc_btb_btb_ram
   import fetch_npc_btb_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF,
   parameter int unsigned TAG_W     = PC_W - BTB_IDX_W - INST_ALIGN_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTB_IDX_W-1:0] rd_idx,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [PC_W-1:0]      rd_target,
   output logic                 rd_cond,
   input  logic                 wr_en,
   input  logic [BTB_IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [PC_W-1:0]      wr_target,
   input  logic                 wr_cond
);

   localparam int unsigned DEPTH = 1 << BTB_IDX_W;

   logic [DEPTH-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_mem    [DEPTH];
   logic [PC_W-1:0]   target_mem [DEPTH];
   logic              cond_mem   [DEPTH];

   // Valid bits: cleared asynchronously, set on training.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= wr_target;
         cond_mem[wr_idx]   <= wr_cond;
      end
   end

   // Asynchronous read returns pre-write contents on a same-cycle update.
   assign rd_valid  = valid_q[rd_idx];
   assign rd_tag    = tag_mem[rd_idx];
   assign rd_target = target_mem[rd_idx];
   assign rd_cond   = cond_mem[rd_idx];

endmodule

// File: rtl/fetch_npc_btb.sv
// Fetch-stage next-PC generator with a direct-mapped BTB.
// Ports:
//   clk_i, rst                  clock, asynchronous active-low reset
//   F_stall_i                   hold the fetch PC
//   F_PC_o                      current fetch PC (to predictor)
//   F_btb_hit_o                 BTB tag match on F_PC_o
//   mini_op_branch_o            conditional hit that advances predictor history
//   F_train_predict_i           predictor direction for F_PC_o
//   F_pred_taken_o, F_pred_PC_o final direction and predicted next PC
//   E_redirect_valid_i/PC_i     execute-stage redirect
//   E_update_*                  BTB training write
module fetch_npc_btb
   import fetch_npc_btb_pkg::*;
#(
   parameter int unsigned     PC_W      = PC_W_DEF,
   parameter int unsigned     BTB_IDX_W = BTB_IDX_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
   input  logic            clk_i,
   input  logic            rst,
   input  logic            F_stall_i,
   output logic [PC_W-1:0] F_PC_o,
   output logic            F_btb_hit_o,
   output logic            mini_op_branch_o,
   input  logic            F_train_predict_i,
   output logic            F_pred_taken_o,
   output logic [PC_W-1:0] F_pred_PC_o,
   input  logic            E_redirect_valid_i,
   input  logic [PC_W-1:0] E_redirect_PC_i,
   input  logic            E_update_valid_i,
   input  logic [PC_W-1:0] E_update_PC_i,
   input  logic [PC_W-1:0] E_update_target_i,
   input  logic            E_update_cond_i
);

   localparam int unsigned TAG_W  = PC_W - BTB_IDX_W - INST_ALIGN_BITS;
   localparam int unsigned IDX_LO = INST_ALIGN_BITS;
   localparam int unsigned IDX_HI = BTB_IDX_W + INST_ALIGN_BITS - 1;
   localparam int unsigned TAG_LO = BTB_IDX_W + INST_ALIGN_BITS;

   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_next;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [PC_W-1:0]  rd_target;
   logic             rd_cond;
   logic             hit;
   logic             taken;
   logic             unused_lsbs;

   // Alignment bits of the trained PC carry no index or tag information.
   assign unused_lsbs = ^E_update_PC_i[IDX_LO-1:0];

   fetch_npc_btb_btb_ram #(
      .PC_W      (PC_W),
      .BTB_IDX_W (BTB_IDX_W),
      .TAG_W     (TAG_W)
   ) u_btb_ram (
      .clk       (clk_i),
      .rst       (rst),
      .rd_idx    (pc_q[IDX_HI:IDX_LO]),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_target (rd_target),
      .rd_cond   (rd_cond),
      .wr_en     (E_update_valid_i),
      .wr_idx    (E_update_PC_i[IDX_HI:IDX_LO]),
      .wr_tag    (E_update_PC_i[PC_W-1:TAG_LO]),
      .wr_target (E_update_target_i),
      .wr_cond   (E_update_cond_i)
   );

   // Lookup and prediction, combinational on the current fetch PC.
   assign hit   = rd_valid && (rd_tag == pc_q[PC_W-1:TAG_LO]);
   assign taken = hit && (!rd_cond || F_train_predict_i);

   // History only advances on a fetch that actually proceeds.
   assign mini_op_branch_o = hit && rd_cond && !F_stall_i && !E_redirect_valid_i;
   assign F_btb_hit_o      = hit;
   assign F_pred_taken_o   = taken;
   assign F_pred_PC_o      = taken ? rd_target : pc_q + PC_W'(4);
   assign F_PC_o           = pc_q;

   // Next-PC select: redirect beats stall beats prediction.
   always_comb begin
      pc_next = F_pred_PC_o;
      if (E_redirect_valid_i) begin
         pc_next = E_redirect_PC_i;
      end else if (F_stall_i) begin
         pc_next = pc_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

endmodule
